// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver sampled on a shared x16 baud tick.
// The line is LSB first, with an optional parity bit and one stop bit, and idles high.
// Each received word goes into a single-entry valid/ready holding register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle; a low level on a tick starts a frame
// START  | confirm the start bit at mid-bit, otherwise treat it as a glitch
// DATA   | shift in 8 data bits, LSB first, one per sample point
// PARITY | capture the parity bit (only when parity is latched on)
// STOP   | sample the stop bit and write the word into the holding register
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       baud_tick_x16_i,
   input  logic       parity_en_i,
   input  logic       parity_odd_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       rx_parity_err_o,
   output logic       rx_frame_err_o,
   output logic       rx_overrun_o
);

   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [SS-1:0] r_sync;
   logic [3:0]  r_tick_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shreg;
   logic        r_rx_par;
   logic        r_par_en;
   logic        r_par_odd;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_perr;
   logic        r_ferr;
   logic        r_overrun;

   logic        w_rxs;
   logic        w_sample;
   logic        w_frame_start;
   logic        w_bit_clr;
   logic        w_bit_shift;
   logic        w_par_store;
   logic        w_word_done;
   logic        w_pop;
   logic        w_perr;
   logic        w_ferr;

   // Bring the asynchronous line into the clock domain; idles high out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_sync <= '1;
      else         r_sync <= {r_sync[SS-2:0], rx_i};
   end

   assign w_rxs    = r_sync[SS-1];
   assign w_sample = baud_tick_x16_i && (r_tick_cnt == 4'd7);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (baud_tick_x16_i && !w_rxs) w_state_nxt = S_START;
         S_START:  if (w_sample) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
         S_DATA:   if (w_sample && (r_bit_idx == 3'd7))
                      w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_sample) w_state_nxt = S_STOP;
         S_STOP:   if (w_sample) w_state_nxt = w_rxs ? S_IDLE : S_BREAK;
         S_BREAK:  if (baud_tick_x16_i && w_rxs) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Per-state datapath strobes.
   always_comb begin
      w_frame_start = 1'b0;
      w_bit_clr     = 1'b0;
      w_bit_shift   = 1'b0;
      w_par_store   = 1'b0;
      w_word_done   = 1'b0;
      case (r_state)
         S_IDLE:   w_frame_start = baud_tick_x16_i && !w_rxs;
         S_START:  w_bit_clr     = w_sample && !w_rxs;
         S_DATA:   w_bit_shift   = w_sample;
         S_PARITY: w_par_store   = w_sample;
         S_STOP:   w_word_done   = w_sample;
         default:  ;
      endcase
   end

   // Tick phase counter; it is held at zero while no frame is in progress.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_tick_cnt <= 4'd0;
      else if (r_state == S_IDLE || r_state == S_BREAK)
         r_tick_cnt <= 4'd0;
      else if (baud_tick_x16_i)
         r_tick_cnt <= r_tick_cnt + 4'd1;
   end

   // Bit index, shift register, parity capture and per-frame configuration latch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bit_idx <= 3'd0;
         r_shreg   <= 8'd0;
         r_rx_par  <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
      end else begin
         if (w_frame_start) begin
            r_par_en  <= parity_en_i;
            r_par_odd <= parity_odd_i;
         end
         if (w_bit_clr)
            r_bit_idx <= 3'd0;
         else if (w_bit_shift)
            r_bit_idx <= r_bit_idx + 3'd1;
         if (w_bit_shift)
            r_shreg <= {w_rxs, r_shreg[7:1]};
         if (w_par_store)
            r_rx_par <= w_rxs;
      end
   end

   assign w_pop  = r_valid && rx_ready_i;
   assign w_perr = r_par_en && (r_rx_par != (^r_shreg ^ r_par_odd));
   assign w_ferr = !w_rxs;

   // Holding register: a write is accepted when the register is empty or is popped in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data    <= 8'd0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_word_done && r_valid && !w_pop;
         if (w_word_done && (!r_valid || w_pop)) begin
            r_data  <= r_shreg;
            r_perr  <= w_perr;
            r_ferr  <= w_ferr;
            r_valid <= 1'b1;
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data_o       = r_data;
   assign rx_valid_o      = r_valid;
   assign rx_parity_err_o = r_perr;
   assign rx_frame_err_o  = r_ferr;
   assign rx_overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vectors for uart_rx. Frames are listed in a table and checked in a loop,
// and the glitch, break, overrun and reset cases are written out as separate sequences.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic       pen;
   logic       podd;
   logic       rx;
   logic       ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       perr;
   logic       ferr;
   logic       ovr;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .baud_tick_x16_i (baud_tick),
      .parity_en_i     (pen),
      .parity_odd_i    (podd),
      .rx_i            (rx),
      .rx_data_o       (rx_data),
      .rx_valid_o      (rx_valid),
      .rx_ready_i      (ready),
      .rx_parity_err_o (perr),
      .rx_frame_err_o  (ferr),
      .rx_overrun_o    (ovr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         use_par;
      bit         odd;
      bit         pb;
      bit         stop;
      bit         eperr;
      bit         eferr;
   } vec_t;

   vec_t       vecs[6];
   int         n_pass  = 0;
   int         n_total = 0;
   int         div     = 1;

   // Monitor: records every popped word and counts valid and overrun cycles.
   logic [7:0] q_data[$];
   bit         q_perr[$];
   bit         q_ferr[$];
   int         n_valid_cyc = 0;
   int         n_ovr_cyc   = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) n_valid_cyc++;
         if (ovr)      n_ovr_cyc++;
         if (rx_valid && ready) begin
            q_data.push_back(rx_data);
            q_perr.push_back(perr);
            q_ferr.push_back(ferr);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clk_cycle(input bit t);
      @(posedge clk);
      #2;
      baud_tick = t;
   endtask

   task automatic one_tick();
      clk_cycle(1'b1);
      for (int k = 1; k < div; k++) clk_cycle(1'b0);
   endtask

   task automatic line_ticks(input bit v, input int n);
      rx = v;
      for (int k = 0; k < n; k++) one_tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit use_par, input bit pb, input bit stop);
      line_ticks(1'b0, 16);
      for (int b = 0; b < 8; b++) line_ticks(d[b], 16);
      if (use_par) line_ticks(pb, 16);
      line_ticks(stop, 16);
   endtask

   // Checks that exactly one word arrived since read index rd and compares its value and flags.
   task automatic chk_one(input string name, input int rd, input logic [7:0] ed,
                          input bit ep, input bit ef);
      chk({name, " count"}, q_data.size() - rd, 1);
      if (q_data.size() > rd) begin
         chk({name, " data"}, q_data[rd], ed);
         chk({name, " perr"}, q_perr[rd], ep);
         chk({name, " ferr"}, q_ferr[rd], ef);
      end
   endtask

   initial begin
      int rd;
      int vc0;
      int ov0;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0; baud_tick = 1'b0; pen = 1'b0; podd = 1'b0; rx = 1'b1; ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset valid", rx_valid, 0);
      chk("reset data", rx_data, 0);
      chk("reset perr", perr, 0);
      chk("reset ferr", ferr, 0);
      chk("reset ovr", ovr, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      line_ticks(1'b1, 32);

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         rd  = q_data.size();
         vc0 = n_valid_cyc;
         pen  = vecs[i].use_par;
         podd = vecs[i].odd;
         send_frame(vecs[i].d, vecs[i].use_par, vecs[i].pb, vecs[i].stop);
         line_ticks(1'b1, 24);
         chk_one($sformatf("vec%0d", i), rd, vecs[i].d, vecs[i].eperr, vecs[i].eferr);
         chk($sformatf("vec%0d valid cycles", i), n_valid_cyc - vc0, 1);
      end

      // A short low glitch is ignored, and the next frame is received intact.
      pen = 1'b0; podd = 1'b0;
      rd = q_data.size();
      line_ticks(1'b0, 4);
      line_ticks(1'b1, 32);
      chk("glitch no word", q_data.size() - rd, 0);
      chk("glitch valid", rx_valid, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      line_ticks(1'b1, 24);
      chk_one("after glitch", rd, 8'h3C, 1'b0, 1'b0);

      // Stop bit low followed by a held-low line: the word has a frame error and no new frame starts.
      rd = q_data.size();
      send_frame(8'h81, 1'b0, 1'b0, 1'b0);
      line_ticks(1'b0, 40);
      chk_one("break", rd, 8'h81, 1'b0, 1'b1);
      line_ticks(1'b1, 40);
      chk("break no extra word", q_data.size() - rd, 1);
      chk("break valid idle", rx_valid, 0);

      // Overrun while the consumer stalls.
      @(posedge clk); #2;
      ready = 1'b0;
      rd  = q_data.size();
      ov0 = n_ovr_cyc;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      line_ticks(1'b1, 24);
      chk("stall valid", rx_valid, 1);
      chk("stall data", rx_data, 8'h11);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      line_ticks(1'b1, 24);
      chk("overrun pulses", n_ovr_cyc - ov0, 1);
      chk("overrun kept data", rx_data, 8'h11);
      chk("overrun kept valid", rx_valid, 1);
      chk("overrun kept ferr", ferr, 0);
      @(posedge clk); #2;
      ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("drain valid", rx_valid, 0);
      chk_one("drain", rd, 8'h11, 1'b0, 1'b0);
      chk("drain data held", rx_data, 8'h11);

      // Reset in the middle of DATA, then a frame with a tick on every third clock.
      rd = q_data.size();
      line_ticks(1'b0, 16);
      line_ticks(1'b1, 16);
      line_ticks(1'b0, 16);
      line_ticks(1'b1, 8);
      @(posedge clk); #2;
      rst_n = 1'b0;
      rx    = 1'b1;
      @(negedge clk);
      chk("midreset valid", rx_valid, 0);
      chk("midreset data", rx_data, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      div = 3;
      line_ticks(1'b1, 24);
      chk("midreset no word", q_data.size() - rd, 0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      line_ticks(1'b1, 24);
      chk_one("slow tick", rd, 8'h5A, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
